// File: rtl/mux_arb_defs_pkg.sv
// Shared encodings and default widths for the round-robin mux controller.
package mux_arb_defs;

   typedef enum logic {
      VACIO = 1'b0,
      LLENO = 1'b1
   } estado_t;

   localparam logic CANAL0 = 1'b0;
   localparam logic CANAL1 = 1'b1;

   localparam int DEF_DATA_WIDTH = 2;
   localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/arbitro_rr_2.sv
// Two-way round-robin arbiter: combinational grant plus the priority pointer,
// which moves only when a grant is actually used.
module arbitro_rr_2
   import mux_arb_defs::*;
(
   input  logic clk,
   input  logic reset,
   input  logic valid_in0,
   input  logic valid_in1,
   input  logic can_load,
   input  logic xfer,
   output logic grant_valid,
   output logic grant_idx
);

   logic prio;

   always_ff @(posedge clk) begin
      if (reset)
         prio <= CANAL0;
      else if (xfer)
         prio <= ~grant_idx;
   end

   always_comb begin
      grant_idx = CANAL0;
      if (valid_in0 && valid_in1)
         grant_idx = prio;
      else if (valid_in1)
         grant_idx = CANAL1;
   end

   assign grant_valid = can_load & (valid_in0 | valid_in1);

endmodule

// File: rtl/mux_arbitro_rr.sv
// Round-robin front end for the registered 2x1 mux. Optional per-channel
// saturating grant counters are built when MUX_ARB_CONTADORES_EN is defined.
module mux_arbitro_rr
   import mux_arb_defs::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in0,
   input  logic [DATA_WIDTH-1:0] data_in0,
   output logic                  ready_in0,
   input  logic                  valid_in1,
   input  logic [DATA_WIDTH-1:0] data_in1,
   output logic                  ready_in1,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  ready_out,
`ifdef MUX_ARB_CONTADORES_EN
   output logic                  selector_out,
   output logic [CNT_WIDTH-1:0]  grant_cnt0,
   output logic [CNT_WIDTH-1:0]  grant_cnt1
`else
   output logic                  selector_out
`endif
);

   estado_t               state, state_nxt;
   logic                  can_load, grant_valid, grant_idx, xfer;
   logic [DATA_WIDTH-1:0] mux_out;

   // Reset gates can_load so nothing is accepted in a reset cycle.
   assign can_load = ~reset & ((state == VACIO) | ready_out);

   arbitro_rr_2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .valid_in0   (valid_in0),
      .valid_in1   (valid_in1),
      .can_load    (can_load),
      .xfer        (xfer),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign ready_in0 = grant_valid & (grant_idx == CANAL0);
   assign ready_in1 = grant_valid & (grant_idx == CANAL1);
   assign xfer      = grant_valid;

   assign mux_out = (grant_idx == CANAL1) ? data_in1 : data_in0;

   always_ff @(posedge clk) begin
      if (reset)
         state <= VACIO;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (can_load)
         state_nxt = xfer ? LLENO : VACIO;
   end

   always_comb begin
      valid_out = (state == LLENO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out     <= '0;
         selector_out <= CANAL0;
      end else if (xfer) begin
         data_out     <= mux_out;
         selector_out <= grant_idx;
      end
   end

`ifdef MUX_ARB_CONTADORES_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (ready_in0 && grant_cnt0 != '1)
            grant_cnt0 <= grant_cnt0 + 1'b1;
         if (ready_in1 && grant_cnt1 != '1)
            grant_cnt1 <= grant_cnt1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// Directed bench for mux_arbitro_rr with hand-computed expectations.
module tb_mux_arbitro_rr;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_in0, valid_in1, ready_out;
   logic [1:0] data_in0, data_in1;
   logic       ready_in0, ready_in1, valid_out, selector_out;
   logic [1:0] data_out;
`ifdef MUX_ARB_CONTADORES_EN
   logic [1:0] grant_cnt0, grant_cnt1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_arbitro_rr #(.DATA_WIDTH(2), .CNT_WIDTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_in0    (valid_in0),
      .data_in0     (data_in0),
      .ready_in0    (ready_in0),
      .valid_in1    (valid_in1),
      .data_in1     (data_in1),
      .ready_in1    (ready_in1),
      .valid_out    (valid_out),
      .data_out     (data_out),
      .ready_out    (ready_out),
`ifdef MUX_ARB_CONTADORES_EN
      .selector_out (selector_out),
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1)
`else
      .selector_out (selector_out)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; valid_in0 = 1'b1; data_in0 = 2'b10;
      valid_in1 = 1'b0; data_in1 = 2'b00; ready_out = 1'b1;
      #1;
      chk("rst_rdy0", ready_in0, 1'b0);
      chk("rst_rdy1", ready_in1, 1'b0);
      tick();
      chk("rst_vout", valid_out, 1'b0);
      chk("rst_dout", data_out, 2'b00);
      chk("rst_sel",  selector_out, 1'b0);

      // single transfer on channel 0
      reset = 1'b0;
      #1;
      chk("t1_rdy0", ready_in0, 1'b1);
      chk("t1_rdy1", ready_in1, 1'b0);
      tick();
      chk("t1_vout", valid_out, 1'b1);
      chk("t1_dout", data_out, 2'b10);
      chk("t1_sel",  selector_out, 1'b0);

      // alternation from reset
      reset = 1'b1; valid_in0 = 1'b0;
      tick();
      reset = 1'b0; valid_in0 = 1'b1; data_in0 = 2'b01;
      valid_in1 = 1'b1; data_in1 = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("alt_rdy0", ready_in0, (i % 2 == 0));
         chk("alt_rdy1", ready_in1, (i % 2 == 1));
         tick();
         chk("alt_dout", data_out, (i % 2 == 1) ? 2'b11 : 2'b01);
         chk("alt_sel",  selector_out, (i % 2 == 1));
      end

      // channel 1 alone for four cycles
      valid_in0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("solo1_rdy1", ready_in1, 1'b1);
         tick();
         chk("solo1_dout", data_out, 2'b11);
         chk("solo1_sel",  selector_out, 1'b1);
      end

      // tie now resolves to channel 0 (prio back to 0)
      valid_in0 = 1'b1;
      #1;
      chk("tie_rdy0", ready_in0, 1'b1);
      chk("tie_rdy1", ready_in1, 1'b0);
      tick();
      chk("tie_dout", data_out, 2'b01);

      // stall: output held, no readies
      ready_out = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_rdy0", ready_in0, 1'b0);
         chk("stall_rdy1", ready_in1, 1'b0);
         tick();
         chk("stall_vout", valid_out, 1'b1);
         chk("stall_dout", data_out, 2'b01);
      end
      ready_out = 1'b1;
      #1;
      chk("unstall_rdy1", ready_in1, 1'b1);
      chk("unstall_rdy0", ready_in0, 1'b0);
      tick();
      chk("unstall_dout", data_out, 2'b11);
      chk("unstall_sel",  selector_out, 1'b1);

      // drain with no requesters: empties, data holds
      valid_in0 = 1'b0; valid_in1 = 1'b0;
      tick();
      chk("drain_vout", valid_out, 1'b0);
      chk("drain_dout", data_out, 2'b11);
      chk("drain_sel",  selector_out, 1'b1);

      // reset while holding a word (prio is 1 after the load below)
      valid_in0 = 1'b1; data_in0 = 2'b10;
      tick();
      chk("hold_vout", valid_out, 1'b1);
      chk("hold_dout", data_out, 2'b10);
      reset = 1'b1;
      #1;
      chk("midrst_rdy0", ready_in0, 1'b0);
      chk("midrst_rdy1", ready_in1, 1'b0);
      tick();
      chk("midrst_vout", valid_out, 1'b0);
      chk("midrst_dout", data_out, 2'b00);
      reset = 1'b0; valid_in1 = 1'b1;
      #1;
      chk("midrst_prio", ready_in0, 1'b1);

`ifdef MUX_ARB_CONTADORES_EN
      reset = 1'b1; valid_in1 = 1'b0;
      tick();
      chk("cnt_rst0", grant_cnt0, 2'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("cnt_sat0", grant_cnt0, 2'd3);
      chk("cnt_idle1", grant_cnt1, 2'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_arbitro_rr.md
# mux_arbitro_rr

Round-robin controller for the two-input registered 2-bit mux with memory. It drives the mux selector and the output register enable, sharing one registered output between two requesters over valid/ready handshakes. It sits between two producers and one downstream consumer, and replaces the free-running selector input with fair, flow-controlled arbitration.

## Interface
Parameters:
- DATA_WIDTH, 2: width of each data channel.
- CNT_WIDTH, 8: width of the grant counters (used only with MUX_ARB_CONTADORES_EN).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in0  input  1  requester 0 has data.
- data_in0  input  DATA_WIDTH  requester 0 data.
- ready_in0  output  1  requester 0 transfer accepted this cycle.
- valid_in1  input  1  requester 1 has data.
- data_in1  input  DATA_WIDTH  requester 1 data.
- ready_in1  output  1  requester 1 transfer accepted this cycle.
- valid_out  output  1  data_out holds an unconsumed word.
- data_out  output  DATA_WIDTH  registered mux output.
- ready_out  input  1  consumer takes data_out this cycle.
- selector_out  output  1  source channel of the current data_out.
- grant_cnt0, grant_cnt1  output  CNT_WIDTH  per-channel accepted-transfer counts (macro only).

## Operation
- Output stage states: VACIO (valid_out=0) and LLENO (valid_out=1).
- can_load = (state==VACIO) | ready_out.
- Priority pointer prio: 0 means channel 0 wins a tie.
- Grant (combinational): when can_load, exactly one of valid_in0/valid_in1 high → that channel wins; both high → channel prio wins; neither → no grant.
- ready_inN = can_load & grant==N. At most one ready_in is high per cycle.
- Transfer on channel N (valid_inN & ready_inN): data_out<=data_inN, selector_out<=N, state→LLENO, prio<=~N (last winner drops to lowest priority).
- can_load with no grant: state→VACIO; data_out and selector_out hold their values.
- LLENO with ready_out=0: everything holds; both ready_in are 0.
- prio changes only on a transfer.
- Requesters keep valid_inN and data_inN stable until accepted. A valid dropped before acceptance is simply not granted.

## Timing
- Reset values: valid_out=0, data_out=0, selector_out=0, prio=0, state=VACIO, grant counters=0. ready_in0 and ready_in1 are 0 during any cycle with reset high.
- Latency: input accepted in cycle t appears on data_out/valid_out in cycle t+1.
- Throughput: one word per cycle while ready_out=1. Both valid continuously gives strict alternation 0,1,0,1,… starting from the prio value.
- Combinational paths ready_out→ready_inN and valid_inN→ready_inN exist. There is no path to valid_out or data_out.
- Reset mid-operation: a held word is discarded (valid_out=0 next cycle), and no transfer is accepted in the reset cycle.

## Configuration
- MUX_ARB_CONTADORES_EN defined:
  - grant_cnt0 and grant_cnt1 exist.
  - Each increments by 1 on a transfer on its channel.
  - Each saturates at all-ones (no wrap).
  - Both clear on reset.
- MUX_ARB_CONTADORES_EN undefined: the counter ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package/header mux_arb_defs: state encodings VACIO=1'b0 and LLENO=1'b1; channel constants CANAL0=1'b0 and CANAL1=1'b1; default widths.
- One sub-module, arbitro_rr_2: holds the prio register and the combinational grant for inputs valid_in0, valid_in1, can_load, and a transfer strobe. Its outputs are grant_valid and grant_idx.
- Top level: instantiates arbitro_rr_2, the existing 2-bit 2x1 mux (selector=grant_idx), the output register with load enable, and the optional counters.

## Test plan
- Reset, then valid_in0=1, data_in0=2'b10, ready_out=1 → ready_in0=1 the same cycle; next cycle valid_out=1, data_out=2'b10, selector_out=0.
- Both valid continuously (data_in0=2'b01, data_in1=2'b11), ready_out=1, from reset → data_out sequence 01,11,01,11; selector_out 0,1,0,1.
- Only valid_in1 high for 4 cycles → 4 consecutive grants to channel 1; prio ends at 0.
- Output LLENO with ready_out=0 for 3 cycles, both valid high → data_out is stable; ready_in0=ready_in1=0; first grant after ready_out rises goes to channel prio.
- Reset asserted while valid_out=1 → next cycle valid_out=0, data_out=0, prio=0, and no ready_in during reset.
- With MUX_ARB_CONTADORES_EN and CNT_WIDTH=2: 5 channel-0 transfers → grant_cnt0=3 (saturated), grant_cnt1=0.
